// File: rtl/nc_fetch_responder.sv
// Non-cacheable fetch responder: turns one-cycle icache fetch pulses into a
// backing-memory read (valid/ready request, unthrottled response) and returns
// one grant pulse per accepted request. One extra request can be queued in a
// single pending slot. Requests arriving while that slot is full are dropped
// and flagged. A WAIT watchdog aborts requests that never get a response. The
// late responses of aborted requests are counted and then discarded.
module nc_fetch_responder #(
  parameter int ADDR_WIDTH     = 40,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_nc_valid_i,
  input  logic [ADDR_WIDTH-1:0] req_nc_vaddr_i,
  output logic                  l2_grant_valid_o,
  output logic [DATA_WIDTH-1:0] l2_resp_data_o,
  output logic                  l2_resp_err_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data_i,
  input  logic                  mem_rsp_err_i,
  output logic                  busy_o,
  output logic                  drop_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            stale_q, stale_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic                  grant_q, grant_d;
  logic                  mreq_valid_q, mreq_valid_d;
  logic                  busy_q, busy_d;
  logic                  drop_q, drop_d;

  logic [ADDR_WIDTH-1:0] aligned_addr;
  logic                  stale_hit;
  logic                  live_rsp;
  logic                  timeout_hit;
  logic                  consume;

  // Next-state, pending-slot, stale-counter and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    cnt_d        = cnt_q;
    stale_d      = stale_q;
    data_d       = data_q;
    err_d        = err_q;
    drop_d       = drop_q;

    // Fetches are line-aligned to 8 bytes.
    aligned_addr = req_nc_vaddr_i & ~(ADDR_WIDTH'(7));
    // Any response is owed to an aborted request while stale_q is nonzero.
    stale_hit    = mem_rsp_valid_i && (stale_q != 2'd0);
    live_rsp     = mem_rsp_valid_i && (stale_q == 2'd0) && (state_q == ST_WAIT);
    // A live response in the final WAIT cycle wins over the watchdog.
    timeout_hit  = (state_q == ST_WAIT) && !live_rsp && (cnt_q == CNT_LAST);
    consume      = (state_q == ST_RESP) && pend_valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_nc_valid_i) begin
          cur_addr_d = aligned_addr;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_req_ready_i) begin
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (live_rsp) begin
          data_d  = mem_rsp_data_i;
          err_d   = mem_rsp_err_i;
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (pend_valid_q) begin
          cur_addr_d   = pend_addr_q;
          pend_valid_d = 1'b0;
          state_d      = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Requests outside IDLE go to the slot. A slot being consumed this
    // cycle can be refilled at the same time.
    if (req_nc_valid_i && (state_q != ST_IDLE)) begin
      if (!pend_valid_q || consume) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = aligned_addr;
      end else begin
        drop_d = 1'b1;
      end
    end

    // Discard and timeout in the same cycle cancel each other out.
    unique case ({stale_hit, timeout_hit})
      2'b10:   stale_d = stale_q - 2'd1;
      2'b01:   stale_d = (stale_q == 2'd3) ? stale_q : stale_q + 2'd1;
      default: stale_d = stale_q;
    endcase

    grant_d      = (state_d == ST_RESP);
    mreq_valid_d = (state_d == ST_REQ);
    busy_d       = (state_d != ST_IDLE) || pend_valid_d;
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cur_addr_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      cnt_q        <= '0;
      stale_q      <= 2'd0;
      data_q       <= '0;
      err_q        <= 1'b0;
      grant_q      <= 1'b0;
      mreq_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      cnt_q        <= cnt_d;
      stale_q      <= stale_d;
      data_q       <= data_d;
      err_q        <= err_d;
      grant_q      <= grant_d;
      mreq_valid_q <= mreq_valid_d;
      busy_q       <= busy_d;
      drop_q       <= drop_d;
    end
  end

  assign l2_grant_valid_o = grant_q;
  assign l2_resp_data_o   = data_q;
  assign l2_resp_err_o    = err_q;
  assign mem_req_valid_o  = mreq_valid_q;
  assign mem_req_addr_o   = cur_addr_q;
  assign busy_o           = busy_q;
  assign drop_o           = drop_q;

endmodule

// File: tb/tb_nc_fetch_responder.sv
// Bench for nc_fetch_responder (TIMEOUT_CYCLES=4): vector table, hand-written
// pending/drop/reset sequences, and randomized transactions vs. a
// latency/result model.
module tb_nc_fetch_responder;
  localparam int AW = 40;
  localparam int DW = 64;
  localparam int TO = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          req_nc_valid_i;
  logic [AW-1:0] req_nc_vaddr_i;
  logic          l2_grant_valid_o;
  logic [DW-1:0] l2_resp_data_o;
  logic          l2_resp_err_o;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i;
  logic [AW-1:0] mem_req_addr_o;
  logic          mem_rsp_valid_i;
  logic [DW-1:0] mem_rsp_data_i;
  logic          mem_rsp_err_i;
  logic          busy_o;
  logic          drop_o;

  nc_fetch_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_nc_valid_i(req_nc_valid_i), .req_nc_vaddr_i(req_nc_vaddr_i),
    .l2_grant_valid_o(l2_grant_valid_o), .l2_resp_data_o(l2_resp_data_o),
    .l2_resp_err_o(l2_resp_err_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .mem_rsp_err_i(mem_rsp_err_i),
    .busy_o(busy_o), .drop_o(drop_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] data;
    logic          err;
    int            rd;       // cycles ready is held low
    int            k;        // WAIT cycle index of the response (>=TO: none)
    bit            late;     // deliver the aborted response afterwards
    logic [DW-1:0] exp_data;
    logic          exp_err;
    int            exp_lat;  // request cycle to grant cycle
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    req_nc_valid_i  = 1'b0;
    req_nc_vaddr_i  = '0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    mem_rsp_err_i   = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
  endtask

  // Drives one request and acts as the memory; returns what came back.
  task automatic run_txn(input logic [AW-1:0] a, input logic [AW-1:0] xa,
                         input logic [DW-1:0] d, input logic e, input int rd, input int k,
                         output logic [DW-1:0] gd, output logic ge, output int lat,
                         output int bad_addr, output logic busy_after, output logic held);
    int  vcnt;
    int  w;
    bit  in_wait;
    bit  go_wait;
    vcnt = 0; w = 0; in_wait = 0; lat = -1; bad_addr = 0;
    gd = '0; ge = 1'b0; busy_after = 1'b1; held = 1'b0;
    req_nc_valid_i = 1'b1;
    req_nc_vaddr_i = a;
    for (int c = 1; c <= 40; c++) begin
      tick();
      clear_inputs();
      if (l2_grant_valid_o) begin
        lat = c;
        gd  = l2_resp_data_o;
        ge  = l2_resp_err_o;
        break;
      end
      go_wait = 0;
      if (in_wait) begin
        if (w == k) begin
          mem_rsp_valid_i = 1'b1;
          mem_rsp_data_i  = d;
          mem_rsp_err_i   = e;
        end
        w++;
      end
      if (mem_req_valid_o) begin
        if (mem_req_addr_o !== xa) bad_addr++;
        if (vcnt == rd) begin
          mem_req_ready_i = 1'b1;
          go_wait = 1;
        end
        vcnt++;
      end
      if (go_wait) begin
        in_wait = 1;
        w = 0;
      end
    end
    if (lat >= 0) begin
      tick();
      busy_after = busy_o;
      held = (l2_resp_data_o === gd) && (l2_resp_err_o === ge);
    end
  endtask

  // Delivers the overdue response of an aborted request; it must not grant.
  task automatic late_rsp(input int pre, input logic [DW-1:0] d, output bit saw);
    saw = 0;
    for (int i = 0; i < pre; i++) begin
      tick();
      if (l2_grant_valid_o) saw = 1;
    end
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = d;
    mem_rsp_err_i   = 1'b0;
    tick();
    clear_inputs();
    for (int i = 0; i < 4; i++) begin
      if (l2_grant_valid_o) saw = 1;
      tick();
    end
  endtask

  task automatic check_txn(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] xa,
                           input logic [DW-1:0] d, input logic e, input int rd, input int k,
                           input logic [DW-1:0] xd, input logic xe, input int xl);
    logic [DW-1:0] gd;
    logic          ge;
    int            lat;
    int            bad;
    logic          busy_after;
    logic          held;
    run_txn(a, xa, d, e, rd, k, gd, ge, lat, bad, busy_after, held);
    $display("txn %s addr=%h rd=%0d k=%0d -> lat=%0d data=%h err=%0d", tag, a, rd, k, lat, gd, ge);
    chk({tag, " latency"}, DW'(lat), DW'(xl));
    chk({tag, " data"}, gd, xd);
    chk({tag, " err"}, DW'(ge), DW'(xe));
    chk({tag, " addr mismatches"}, DW'(bad), DW'(0));
    chk({tag, " busy after"}, DW'(busy_after), DW'(0));
    chk({tag, " result held"}, DW'(held), DW'(1));
  endtask

  initial begin
    bit saw;
    logic [63:0] r;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic e;
    int rd, k;

    vecs[0] = '{40'h80_0000_1004, 40'h80_0000_1000, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 0, 0, 1'b0,
                64'hDEAD_BEEF_CAFE_F00D, 1'b0, 3};
    vecs[1] = '{40'h12_3456_789F, 40'h12_3456_7898, 64'h0123_4567_89AB_CDEF, 1'b0, 5, 0, 1'b0,
                64'h0123_4567_89AB_CDEF, 1'b0, 8};
    vecs[2] = '{40'h00_0000_0007, 40'h00_0000_0000, 64'h0000_0000_0000_1234, 1'b1, 0, 1, 1'b0,
                64'h0000_0000_0000_1234, 1'b1, 4};
    vecs[3] = '{40'hFF_FFFF_FFF8, 40'hFF_FFFF_FFF8, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 0, 3, 1'b0,
                64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 6};
    vecs[4] = '{40'h40_0000_0010, 40'h40_0000_0010, 64'h5555_5555_5555_5555, 1'b0, 1, 99, 1'b1,
                64'h0, 1'b1, 7};
    vecs[5] = '{40'h40_0000_0021, 40'h40_0000_0020, 64'h7777_0000_1111_2222, 1'b0, 2, 2, 1'b0,
                64'h7777_0000_1111_2222, 1'b0, 7};
    vecs[6] = '{40'h01_0000_0000, 40'h01_0000_0000, 64'h9999_9999_9999_9999, 1'b0, 0, 4, 1'b1,
                64'h0, 1'b1, 6};
    vecs[7] = '{40'h01_0000_0008, 40'h01_0000_0008, 64'hCAFE_0000_BEEF_0001, 1'b0, 0, 0, 1'b0,
                64'hCAFE_0000_BEEF_0001, 1'b0, 3};

    // Reset state
    clear_inputs();
    rst_i = 1'b1;
    tick();
    tick();
    chk("reset grant", DW'(l2_grant_valid_o), DW'(0));
    chk("reset data", l2_resp_data_o, DW'(0));
    chk("reset err", DW'(l2_resp_err_o), DW'(0));
    chk("reset mem_req_valid", DW'(mem_req_valid_o), DW'(0));
    chk("reset mem_req_addr", DW'(mem_req_addr_o), DW'(0));
    chk("reset busy", DW'(busy_o), DW'(0));
    chk("reset drop", DW'(drop_o), DW'(0));
    rst_i = 1'b0;
    tick();

    // Vector table
    for (int i = 0; i < 8; i++) begin
      check_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_addr, vecs[i].data, vecs[i].err,
                vecs[i].rd, vecs[i].k, vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat);
      if (vecs[i].late) begin
        late_rsp(2, 64'hBAD0_BAD0_BAD0_BAD0, saw);
        $display("txn vec%0d late response, grant seen=%0d", i, saw);
        chk($sformatf("vec%0d late rsp no grant", i), DW'(saw), DW'(0));
      end
    end

    // Refill of the pending slot in the same cycle it is consumed
    do_reset();
    req_nc_valid_i = 1'b1; req_nc_vaddr_i = 40'h100;
    tick(); clear_inputs();
    chk("refill A issued", DW'(mem_req_valid_o), DW'(1));
    mem_req_ready_i = 1'b1;
    tick(); clear_inputs();
    req_nc_valid_i = 1'b1; req_nc_vaddr_i = 40'h20C;
    tick(); clear_inputs();
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 64'hA;
    tick(); clear_inputs();
    chk("refill A grant", DW'(l2_grant_valid_o), DW'(1));
    chk("refill A data", l2_resp_data_o, 64'hA);
    req_nc_valid_i = 1'b1; req_nc_vaddr_i = 40'h317;
    tick(); clear_inputs();
    chk("refill B issued", DW'(mem_req_valid_o), DW'(1));
    chk("refill B addr", DW'(mem_req_addr_o), DW'(40'h208));
    mem_req_ready_i = 1'b1;
    tick(); clear_inputs();
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 64'hB;
    tick(); clear_inputs();
    chk("refill B grant data", DW'(l2_grant_valid_o) << 32 | l2_resp_data_o, (DW'(1) << 32) | 64'hB);
    tick();
    chk("refill C issued", DW'(mem_req_valid_o), DW'(1));
    chk("refill C addr", DW'(mem_req_addr_o), DW'(40'h310));
    mem_req_ready_i = 1'b1;
    tick(); clear_inputs();
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 64'hC;
    tick(); clear_inputs();
    chk("refill C grant data", DW'(l2_grant_valid_o) << 32 | l2_resp_data_o, (DW'(1) << 32) | 64'hC);
    tick();
    chk("refill no drop", DW'(drop_o), DW'(0));
    chk("refill idle busy", DW'(busy_o), DW'(0));
    $display("txn refill sequence done");

    // Pending/drop: A served, B queued, C dropped
    do_reset();
    req_nc_valid_i = 1'b1; req_nc_vaddr_i = 40'h1000;
    tick(); clear_inputs();
    mem_req_ready_i = 1'b1;
    tick(); clear_inputs();
    req_nc_valid_i = 1'b1; req_nc_vaddr_i = 40'h2004;
    tick(); clear_inputs();
    req_nc_valid_i = 1'b1; req_nc_vaddr_i = 40'h3000;
    tick(); clear_inputs();
    chk("drop flag set", DW'(drop_o), DW'(1));
    chk("drop busy", DW'(busy_o), DW'(1));
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 64'h1111;
    tick(); clear_inputs();
    chk("drop A grant data", DW'(l2_grant_valid_o) << 32 | l2_resp_data_o, (DW'(1) << 32) | 64'h1111);
    tick();
    chk("drop B issued next cycle", DW'(mem_req_valid_o), DW'(1));
    chk("drop B addr", DW'(mem_req_addr_o), DW'(40'h2000));
    mem_req_ready_i = 1'b1;
    tick(); clear_inputs();
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 64'h2222;
    tick(); clear_inputs();
    chk("drop B grant data", DW'(l2_grant_valid_o) << 32 | l2_resp_data_o, (DW'(1) << 32) | 64'h2222);
    tick();
    chk("drop C never issued", DW'(mem_req_valid_o) << 1 | DW'(busy_o), DW'(0));
    chk("drop flag sticky", DW'(drop_o), DW'(1));
    $display("txn drop sequence done");

    // Timeout leaves a stale response owed, then reset mid-WAIT clears all
    check_txn("pre-reset timeout", 40'h5000, 40'h5000, 64'h0, 1'b0, 0, 99, 64'h0, 1'b1, 6);
    req_nc_valid_i = 1'b1; req_nc_vaddr_i = 40'h6000;
    tick(); clear_inputs();
    mem_req_ready_i = 1'b1;
    tick(); clear_inputs();
    #3;
    rst_i = 1'b1;
    #1;
    chk("async reset grant", DW'(l2_grant_valid_o), DW'(0));
    chk("async reset err", DW'(l2_resp_err_o), DW'(0));
    chk("async reset busy", DW'(busy_o), DW'(0));
    chk("async reset drop", DW'(drop_o), DW'(0));
    chk("async reset addr", DW'(mem_req_addr_o), DW'(0));
    rst_i = 1'b0;
    saw = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (l2_grant_valid_o) saw = 1;
    end
    chk("reset aborted no grant", DW'(saw), DW'(0));
    check_txn("post-reset", 40'h7003, 40'h7000, 64'h7777, 1'b0, 0, 0, 64'h7777, 1'b0, 3);

    // Randomized transactions vs. result/latency model
    for (int n = 0; n < 60; n++) begin
      bit live;
      r  = {$urandom(), $urandom()};
      a  = r[AW-1:0];
      d  = {$urandom(), $urandom()};
      e  = 1'($urandom_range(0, 1));
      rd = int'($urandom_range(0, 3));
      k  = int'($urandom_range(0, 6));
      live = (k <= TO - 1);
      check_txn($sformatf("rnd%0d", n), a, a & ~(AW'(7)), d, e, rd, k,
                live ? d : DW'(0), live ? e : 1'b1, live ? 3 + rd + k : 2 + rd + TO);
      if (!live) begin
        late_rsp(int'($urandom_range(0, 3)), ~d, saw);
        chk($sformatf("rnd%0d late rsp no grant", n), DW'(saw), DW'(0));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nc_fetch_responder.md
NC_FETCH_RESPONDER -- requirements
Module: nc_fetch_responder

Interface
REQ-001 Parameter ADDR_WIDTH, 40, width of the request and memory address.
REQ-002 Parameter DATA_WIDTH, 64, width of the response line.
REQ-003 Parameter TIMEOUT_CYCLES, 256, maximum number of cycles spent in WAIT before aborting; legal range 2..1024.
REQ-004 Port clk_i, input, 1, the single clock; all logic on rising edge.
REQ-005 Port rst_i, input, 1, reset, asynchronous and active-high.
REQ-006 Port req_nc_valid_i, input, 1, one-cycle non-cacheable fetch request pulse from the icache side.
REQ-007 Port req_nc_vaddr_i, input, ADDR_WIDTH, request address, valid with req_nc_valid_i.
REQ-008 Port l2_grant_valid_o, output, 1, one-cycle response pulse.
REQ-009 Port l2_resp_data_o, output, DATA_WIDTH, response line, valid with l2_grant_valid_o.
REQ-010 Port l2_resp_err_o, output, 1, response is an error (bus error or timeout), valid with grant.
REQ-011 Port mem_req_valid_o / mem_req_ready_i / mem_req_addr_o, out/in/out, 1/1/ADDR_WIDTH, backing-memory read request handshake.
REQ-012 Port mem_rsp_valid_i / mem_rsp_data_i / mem_rsp_err_i, in/in/in, 1/DATA_WIDTH/1, backing-memory read response; always accepted, no backpressure.
REQ-013 Port busy_o, output, 1, high whenever state is not IDLE or the pending slot is full.
REQ-014 Port drop_o, output, 1, sticky flag set when a request is lost because the pending slot was full.

Function
REQ-015 All outputs SHALL be driven from registers.
REQ-016 FSM states: IDLE, REQ, WAIT, RESP.
REQ-017 IDLE + req_nc_valid_i: latch {vaddr[ADDR_WIDTH-1:3],3'b0} into the current address register and go to REQ.
REQ-018 REQ: mem_req_valid_o=1 and mem_req_addr_o=current address; on mem_req_ready_i go to WAIT and clear the timeout counter; address held stable until ready.
REQ-019 WAIT: counter increments each cycle; mem_rsp_valid_i (not stale, REQ-024) latches data/err and goes to RESP.
REQ-020 WAIT, counter reaches TIMEOUT_CYCLES-1 with no response: go to RESP with data=0 and err=1, and increment the stale counter; a response arriving in that same cycle wins (no timeout).
REQ-021 RESP: l2_grant_valid_o=1 for exactly one cycle; next state is REQ loaded from the pending slot if it is full, else IDLE.
REQ-022 Pending slot, one entry: a request arriving outside IDLE is stored there if the slot is empty, or if it is being consumed in that same cycle (consume and refill are simultaneous).
REQ-023 A request arriving while the slot is full and not being consumed SHALL be dropped and SHALL set drop_o.
REQ-024 Stale counter, 2 bits, saturating at 3: while nonzero, the next mem_rsp_valid_i in any state is discarded and decrements it; responses to live requests SHALL never be matched to stale ones.
REQ-025 Minimum latency: request pulse at cycle T; mem_req_valid_o at T+1; ready at T+1; response at T+2; grant at T+3.
REQ-026 l2_resp_data_o and l2_resp_err_o SHALL hold their value until the next grant.
REQ-027 mem_rsp_valid_i in IDLE, REQ or RESP with the stale counter at 0 is a protocol error and SHALL be ignored.

Reset
REQ-028 While rst_i is high: state=IDLE, pending slot empty, counters=0, and all outputs=0 including drop_o.
REQ-029 Reset asserted mid-transaction SHALL abort without a grant; the stale counter is not preserved.

Verification
REQ-030 Basic: req 0x80_0000_1004 at T, ready at T+1, rsp 0xDEAD_BEEF_CAFE_F00D at T+2 -> mem_req_addr_o=0x80_0000_1000, grant at T+3 with that data, err=0.
REQ-031 Backpressure: ready held low 5 cycles -> mem_req_valid_o stays high with a stable address; grant comes 1 cycle after the response.
REQ-032 Timeout (TIMEOUT_CYCLES=4): no response -> grant 4 cycles after WAIT entry with data=0, err=1; a late response 3 cycles later is discarded, and the next request's response is returned correctly.
REQ-033 Pending/drop: req A, then B during WAIT, then C during WAIT -> A served, then B issued the cycle after A's grant; C dropped; drop_o=1 until reset.
REQ-034 Bus error: mem_rsp_err_i=1 with data 0x1234 -> grant with err=1, data=0x1234.
REQ-035 Async reset asserted during WAIT -> outputs 0 immediately, no grant, drop_o cleared.
